mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
- Sits directly downstream of the ALU control decoder. It consumes the 5-bit ALU control code for MULT/MULTU/DIV/DIVU/MTHI/MTLO, and the datapath reads its HI/LO outputs for MFHI/MFLO.
- Uses a radix-2 iterative algorithm: shift-add for multiply, restoring division for divide. It drives a busy signal so the pipeline stalls while an operation is in flight.

Parameters:
- OP_MULT, 5'd12, control code for signed multiply
- OP_MULTU, 5'd13, control code for unsigned multiply
- OP_DIV, 5'd14, control code for signed divide
- OP_DIVU, 5'd15, control code for unsigned divide
- OP_MTHI, 5'd16, control code for write HI
- OP_MTLO, 5'd17, control code for write LO

Ports:
- iCLK  input  1  clock, rising edge
- iRST_n  input  1  asynchronous, active-low reset
- iStart  input  1  request: the operation on iControlSignal is valid this cycle
- iControlSignal  input  5  ALU control code
- iA  input  32  rs operand (multiplicand, dividend, or MTHI/MTLO data)
- iB  input  32  rt operand (multiplier or divisor)
- oBusy  output  1  operation in flight; pipeline must stall any MDU instruction
- oDone  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV
- oHI  output  32  HI register
- oLO  output  32  LO register

Behaviour:
- Reset (async, iRST_n=0): state=IDLE, counter=0, oHI=0, oLO=0, oBusy=0, oDone=0, all working registers=0. Reset asserted mid-operation aborts the operation immediately; HI/LO clear to 0.
- States: IDLE, CALC, FIX.
- IDLE, iStart=1, MTHI/MTLO code: HI (or LO) takes iA at that edge. State stays IDLE, oBusy stays 0, no oDone.
- IDLE, iStart=1, MULT/MULTU/DIV/DIVU code (acceptance edge T0):
  - Latch the operand magnitudes (absolute value for signed ops, raw value for unsigned ops).
  - Latch the result-sign flags: product/quotient sign = A[31]^B[31]; remainder sign = A[31]. Both flags are 0 for unsigned ops.
  - Set counter=0 and go to CALC.
- IDLE, iStart=1, any other code: ignored.
- CALC: one iteration per edge (T1..T32); counter increments each edge. At the edge where counter==31, go to FIX.
  - Multiply: 64-bit product accumulator with conditional add and right shift.
  - Divide: restoring algorithm, one quotient bit per iteration, 32-bit remainder.
- FIX (edge T33):
  - Negate results per the sign flags.
  - Multiply writes HI=product[63:32], LO=product[31:0].
  - Divide writes LO=quotient, HI=remainder.
  - Go to IDLE.
- oBusy=1 whenever state!=IDLE. It is registered, so it is high in the cycles after T0 through T33 inclusive.
- oDone is registered and high for exactly the one cycle after T33.
- Total latency: acceptance to HI/LO valid is 33 edges.
- iStart while busy: ignored; iA/iB/iControlSignal changes while busy have no effect.
- iStart coinciding with the T33 edge: ignored, because the unit is not IDLE. It is accepted on the next cycle if still asserted.
- HI/LO hold their values during CALC and update only in FIX, so MFHI/MFLO reads during busy return the previous values.
- Divide by zero: no trap. The natural restoring result holds: unsigned gives LO=32'hFFFFFFFF, HI=dividend; signed applies sign fixup on top of that.
- Signed 0x80000000 / -1: magnitudes wrap mod 2^32, giving LO=32'h80000000, HI=0.
- All arithmetic is mod 2^32 per register; there is no overflow flag.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
  - When defined: at T0, if either operand of a MULT/MULTU is 0, or the divisor of a DIV/DIVU is 0, the unit skips CALC and goes straight to FIX. Latency becomes 2 edges (T0, T1=FIX); oDone pulses after T1. Results are the same as the full algorithm: multiply gives HI=LO=0; divide by zero gives the values stated above.
  - When undefined: all MULT/DIV ops take the full 33 edges.

Test Plan:
- Reset, then MTHI iA=32'h1234_5678 and MTLO iA=32'h9ABC_DEF0 -> oHI=32'h12345678, oLO=32'h9ABCDEF0 the next cycle, oBusy=0 throughout.
- MULT iA=-3 (32'hFFFFFFFD), iB=7 -> oBusy for 33 cycles, oDone pulse once, HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. MULTU 32'hFFFFFFFF*32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
- DIV iA=-7, iB=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> LO=32'hFFFFFFFF, HI=5. DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0. With MDU_EARLY_OUT_EN, DIVU 5/0 completes in 2 edges with the same values.
- Start MULT, assert iStart with MTHI at cycle 10 of busy -> MTHI ignored, HI changes only at T33 to the product. Pull iRST_n low at cycle 15 of a DIV -> oBusy=0, HI=LO=0 immediately, no oDone.
- iStart held high across the T33 edge with a second MULT -> the second op is accepted on the first IDLE cycle; oDone pulses once per op, and the first op's results are visible between the two pulses.

Source files
------------

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit holding the HI/LO registers.
// Optional early-out on zero operands: define MDU_EARLY_OUT_EN.
module mult_div_unit #(
  parameter logic [4:0] OP_MULT  = 5'd12,
  parameter logic [4:0] OP_MULTU = 5'd13,
  parameter logic [4:0] OP_DIV   = 5'd14,
  parameter logic [4:0] OP_DIVU  = 5'd15,
  parameter logic [4:0] OP_MTHI  = 5'd16,
  parameter logic [4:0] OP_MTLO  = 5'd17
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iStart,
  input  logic [4:0]  iControlSignal,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opd;
  logic        mul;
  logic        qneg;
  logic        rneg;

  logic        is_mul;
  logic        is_div;
  logic        is_sgn;
  logic        accept;
  logic        early;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_step;

  always_comb begin
    is_mul = (iControlSignal == OP_MULT) ||
             (iControlSignal == OP_MULTU);
    is_div = (iControlSignal == OP_DIV) ||
             (iControlSignal == OP_DIVU);
    is_sgn = (iControlSignal == OP_MULT) ||
             (iControlSignal == OP_DIV);
    accept = iStart && (state == IDLE) &&
             (is_mul || is_div);
    a_mag  = (is_sgn && iA[31]) ? -iA : iA;
    b_mag  = (is_sgn && iB[31]) ? -iB : iB;
  end

`ifdef MDU_EARLY_OUT_EN
  assign early = is_mul ? ((iA == '0) || (iB == '0))
                        : (iB == '0);
`else
  assign early = 1'b0;
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} +
               (acc[0] ? {1'b0, opd} : 33'd0);
    mul_step = {mul_sum, acc[31:1]};
  end

  // Divide: acc = {remainder, dividend bits / quotient bits}
  always_comb begin
    div_sh   = {acc[63:32], acc[31]};
    div_diff = div_sh - {1'b0, opd};
    div_ge   = div_sh >= {1'b0, opd};
    div_step = div_ge
      ? {div_diff[31:0], acc[30:0], 1'b1}
      : {div_sh[31:0], acc[30:0], 1'b0};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = early ? FIX : CALC;
      CALC: if (cnt == 5'd31) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt   <= '0;
      acc   <= '0;
      opd   <= '0;
      mul   <= 1'b0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      oHI   <= '0;
      oLO   <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oBusy <= (state_nxt != IDLE);
      oDone <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (iStart && iControlSignal == OP_MTHI) oHI <= iA;
          if (iStart && iControlSignal == OP_MTLO) oLO <= iA;
          if (accept) begin
            cnt  <= '0;
            mul  <= is_mul;
            qneg <= is_sgn && (iA[31] ^ iB[31]);
            rneg <= is_sgn && iA[31];
            opd  <= is_mul ? a_mag : b_mag;
            if (early)
              // Same values the full iteration would settle on
              acc <= is_mul ? 64'd0 : {a_mag, 32'hFFFF_FFFF};
            else
              acc <= {32'd0, is_mul ? b_mag : a_mag};
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          acc <= mul ? mul_step : div_step;
        end
        FIX: begin
          if (mul) begin
            {oHI, oLO} <= qneg ? -acc : acc;
          end else begin
            oLO <= qneg ? -acc[31:0] : acc[31:0];
            oHI <= rneg ? -acc[63:32] : acc[63:32];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
